// File: rtl/recip_div_pkg.sv
// Shared types and helpers for the reciprocal-based divider client.
//   entry_t : numerator FIFO entry; carries a byp flag only when
//             RECIP_DIV_ZERO_BYPASS_EN is defined
//   Q_MAX / Q_MIN : saturated quotient limits
//   sat16() : clamp a 33-bit signed value to the signed 16-bit range
package recip_div_pkg;

  typedef struct packed {
`ifdef RECIP_DIV_ZERO_BYPASS_EN
    logic        byp;
`endif
    logic [15:0] num;
  } entry_t;

  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  function automatic logic [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767) begin
      return Q_MAX;
    end else if (v < -33'sd32768) begin
      return Q_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/recip_div_fifo.sv
// Synchronous FIFO holding parked operands in issue order.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   push, wdata   : write request and data (ignored while full)
//   pop,  rdata   : read request (ignored while empty), head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally at DEPTH.
module recip_div_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/reciprocal_div_client.sv
// Divider front-end: q = sat16((num * recip(den)) >>> QSHIFT).
// Issues den to a reciprocal engine, parks num in an ordered FIFO, and
// combines each returned reciprocal with the FIFO head into a quotient.
// Ports (all req/ack elastic, transfer when req & ack):
//   clk, reset              : clock, synchronous active-high reset
//   t_0_dat/req/ack         : operand in, {num[31:16] signed, den[15:0]}
//   i_0_dat/req/ack         : den out to the engine (combinational path)
//   t_1_dat/req/ack         : reciprocal in from the engine
//   i_1_dat/req/ack         : registered signed quotient out
//   inflight                : FIFO occupancy
//   err                     : sticky, reciprocal arrived with FIFO empty
// Optional feature macro: RECIP_DIV_ZERO_BYPASS_EN -- den==0 operands skip
// the engine and produce a sign-saturated quotient in order.
module reciprocal_div_client
  import recip_div_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned QSHIFT = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            t_0_dat,
  input  logic                   t_0_req,
  output logic                   t_0_ack,
  output logic [15:0]            i_0_dat,
  output logic                   i_0_req,
  input  logic                   i_0_ack,
  input  logic [15:0]            t_1_dat,
  input  logic                   t_1_req,
  output logic                   t_1_ack,
  output logic [15:0]            i_1_dat,
  output logic                   i_1_req,
  input  logic                   i_1_ack,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   err
);

  entry_t             push_entry, head;
  logic               full, empty, push, pop;
  logic               stage_free, t1_xfer;
  logic [15:0]        num, den;
  logic signed [32:0] num_ext, rcp_ext, prod, shifted;
  logic [15:0]        q_q, q_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
`ifdef RECIP_DIV_ZERO_BYPASS_EN
  logic               den_zero, head_byp, byp_pop;
`endif

  assign num     = t_0_dat[31:16];
  assign den     = t_0_dat[15:0];
  assign i_0_dat = den;

  recip_div_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (inflight)
  );

  always_comb begin
    stage_free     = ~vld_q | i_1_ack;
    push_entry     = '0;
    push_entry.num = num;
`ifdef RECIP_DIV_ZERO_BYPASS_EN
    den_zero       = (den == 16'd0);
    push_entry.byp = den_zero;
    // Zero divisors never reach the engine; they are parked directly.
    i_0_req        = t_0_req & ~full & ~den_zero;
    t_0_ack        = ~full & (den_zero | i_0_ack);
    // A bypass head must retire first, so hold off any engine result.
    head_byp       = ~empty & head.byp;
    byp_pop        = head_byp & stage_free;
    t_1_ack        = stage_free & ~head_byp;
`else
    i_0_req        = t_0_req & ~full;
    t_0_ack        = i_0_ack & ~full;
    t_1_ack        = stage_free;
`endif
    push    = t_0_req & t_0_ack;
    t1_xfer = t_1_req & t_1_ack;
    pop     = t1_xfer & ~empty;
`ifdef RECIP_DIV_ZERO_BYPASS_EN
    pop     = pop | byp_pop;
`endif
  end

  // 16x17 signed product fits exactly in 33 bits.
  always_comb begin
    num_ext = {{17{head.num[15]}}, head.num};
    rcp_ext = {17'd0, t_1_dat};
    prod    = num_ext * rcp_ext;
    shifted = prod >>> QSHIFT;
  end

  always_comb begin
    vld_d = vld_q;
    q_d   = q_q;
    err_d = err_q | (t1_xfer & empty);
    if (i_1_ack) vld_d = 1'b0;
    if (t1_xfer && !empty) begin
      vld_d = 1'b1;
      q_d   = sat16(shifted);
    end
`ifdef RECIP_DIV_ZERO_BYPASS_EN
    if (byp_pop) begin
      vld_d = 1'b1;
      q_d   = (head.num == 16'd0) ? 16'h0000 : (head.num[15] ? Q_MIN : Q_MAX);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign i_1_req = vld_q;
  assign i_1_dat = q_q;
  assign err     = err_q;

endmodule

// File: tb/tb_reciprocal_div_client.sv
// Self-checking bench for reciprocal_div_client with a stub reciprocal engine
// (programmable latency / return value) and a queue-based quotient model.
module tb_reciprocal_div_client;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned QSHIFT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] t_0_dat;
  logic        t_0_req, t_0_ack;
  logic [15:0] i_0_dat;
  logic        i_0_req, i_0_ack;
  logic [15:0] t_1_dat;
  logic        t_1_req, t_1_ack;
  logic [15:0] i_1_dat;
  logic        i_1_req, i_1_ack;
  logic [2:0]  inflight;
  logic        err;

  always #5 clk = ~clk;

  reciprocal_div_client #(.DEPTH(DEPTH), .QSHIFT(QSHIFT)) dut (
    .clk(clk), .reset(reset),
    .t_0_dat(t_0_dat), .t_0_req(t_0_req), .t_0_ack(t_0_ack),
    .i_0_dat(i_0_dat), .i_0_req(i_0_req), .i_0_ack(i_0_ack),
    .t_1_dat(t_1_dat), .t_1_req(t_1_req), .t_1_ack(t_1_ack),
    .i_1_dat(i_1_dat), .i_1_req(i_1_req), .i_1_ack(i_1_ack),
    .inflight(inflight), .err(err)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Stub engine / sink controls (changed only at the mid-cycle sample point).
  bit          eng_stall    = 0;
  bit          eng_ack_en   = 1;
  bit          eng_rand_ack = 0;
  int          eng_lat      = 3;
  bit          stub_fixed   = 1;
  logic [15:0] stub_val     = 16'h1000;
  bit          stray_pulse  = 0;
  bit          sink_ack_en  = 1;
  bit          sink_rand    = 0;

  typedef struct { logic [15:0] rcp; int ready; } pend_t;
  pend_t       pend_q[$];
  logic [15:0] issued_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          got_cyc[$];
  int          t1_xfers = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] recip_of(input logic [15:0] den);
    if (stub_fixed) return stub_val;
    return den * 16'd40503 + 16'd4660;
  endfunction

  // Quotient straight from the arithmetic definition.
  function automatic logic [15:0] model_q(input logic [31:0] op);
    longint n, d, s;
    n = longint'($signed(op[31:16]));
    d = longint'(op[15:0]);
`ifdef RECIP_DIV_ZERO_BYPASS_EN
    if (d == 0) return (n > 0) ? 16'h7FFF : ((n < 0) ? 16'h8000 : 16'h0000);
`endif
    s = (n * longint'(recip_of(op[15:0]))) >>> QSHIFT;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Stub reciprocal engine: in-order, each result ready eng_lat cycles after accept.
  initial begin
    bit    stray_now;
    pend_t p;
    i_0_ack = 1'b0;
    t_1_req = 1'b0;
    t_1_dat = '0;
    forever begin
      @(negedge clk);
      i_0_ack   = eng_rand_ack ? 1'($urandom_range(0, 1)) : eng_ack_en;
      stray_now = stray_pulse;
      if (stray_now) begin
        t_1_req = 1'b1;
        t_1_dat = 16'h1234;
      end else if (!eng_stall && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
        t_1_req = 1'b1;
        t_1_dat = pend_q[0].rcp;
      end else begin
        t_1_req = 1'b0;
        t_1_dat = '0;
      end
      #1;
      if (!reset) begin
        if (i_0_req && i_0_ack) begin
          p.rcp   = recip_of(i_0_dat);
          p.ready = cyc + eng_lat;
          pend_q.push_back(p);
          issued_q.push_back(i_0_dat);
        end
        if (t_1_req && t_1_ack) begin
          t1_xfers++;
          if (!stray_now) void'(pend_q.pop_front());
        end
      end
    end
  end

  // Sink and transfer monitor: expected quotients recorded on accept.
  initial begin
    i_1_ack = 1'b0;
    forever begin
      @(negedge clk);
      i_1_ack = sink_rand ? 1'($urandom_range(0, 1)) : sink_ack_en;
      #1;
      if (!reset) begin
        if (t_0_req && t_0_ack) exp_q.push_back(model_q(t_0_dat));
        if (i_1_req && i_1_ack) begin
          got_q.push_back(i_1_dat);
          got_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_queues;
    pend_q.delete(); issued_q.delete(); exp_q.delete();
    got_q.delete(); got_cyc.delete();
    t1_xfers = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset   = 1'b1;
    t_0_req = 1'b0;
    clear_queues();
    @(negedge clk);
    @(negedge clk);
    clear_queues();
    reset = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] op, output bit ok);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      t_0_req = 1'b1;
      t_0_dat = op;
      #1;
      if (t_0_ack) ok = 1;
    end
  endtask

  task automatic idle_src;
    @(negedge clk);
    t_0_req = 1'b0;
    #1;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (inflight == 0 && !i_1_req && got_q.size() == exp_q.size()) ok = 1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (inflight !== 3'd0) $display("FAIL reset_inflight: got %0d want 0", inflight);
    else passed++;
    checks++; if (i_1_req !== 1'b0) $display("FAIL reset_i1_req: got %b want 0", i_1_req);
    else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
    else passed++;
    checks++; if (i_0_req !== 1'b0) $display("FAIL reset_i0_req: got %b want 0", i_0_req);
    else passed++;
  endtask

  task automatic test_single;
    bit seen, ok;
    logic [15:0] e, g;
    sync();
    stub_fixed = 1; stub_val = 16'h1000; eng_lat = 3; sink_ack_en = 1;
    @(negedge clk);
    t_0_dat = 32'h0800_0003;
    t_0_req = 1'b1;
    #1;
    checks++; if (i_0_req !== 1'b1) $display("FAIL single_i0_req: got %b want 1", i_0_req);
    else passed++;
    checks++; if (i_0_dat !== 16'h0003) $display("FAIL single_i0_dat: got %h want 0003", i_0_dat);
    else passed++;
    checks++; if (t_0_ack !== 1'b1) $display("FAIL single_t0_ack: got %b want 1", t_0_ack);
    else passed++;
    idle_src();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (t_1_req && t_1_ack) seen = 1;
    end
    checks++; if (!seen) $display("FAIL single_t1_timeout: got 0 want 1");
    else passed++;
    checks++; if (i_1_req !== 1'b0) $display("FAIL single_early_req: got %b want 0", i_1_req);
    else passed++;
    sync();
    checks++; if (i_1_req !== 1'b1) $display("FAIL single_latency: got %b want 1", i_1_req);
    else passed++;
    checks++; if (i_1_dat !== 16'h2000) $display("FAIL single_q: got %h want 2000", i_1_dat);
    else passed++;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL single_drain: got 0 want 1");
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) $display("FAIL single_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL single_order: got %h want %h", g, e);
        else passed++;
      end
    end
  endtask

  task automatic test_saturation;
    bit ok;
    sync();
    stub_fixed = 1; stub_val = 16'h7FFF; eng_lat = 2;
    got_q.delete(); exp_q.delete();
    send_op(32'h7FFF_0001, ok);
    send_op(32'h8000_0002, ok);
    idle_src();
    wait_drain(ok);
    checks++; if (got_q.size() != 2) $display("FAIL sat_count: got %0d want 2", got_q.size());
    else passed++;
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 16'h7FFF) $display("FAIL sat_pos: got %h want 7fff", got_q[0]);
      else passed++;
      checks++; if (got_q[1] !== 16'h8000) $display("FAIL sat_neg: got %h want 8000", got_q[1]);
      else passed++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_fill;
    bit ok, acc5;
    logic [31:0] ops [5];
    logic [15:0] e, g;
    int t1_at_acc;
    sync();
    stub_fixed = 0; eng_lat = 1; eng_stall = 1; sink_ack_en = 1;
    for (int i = 0; i < 5; i++) ops[i] = {16'($urandom), 16'($urandom_range(1, 65535))};
    for (int i = 0; i < 4; i++) begin
      send_op(ops[i], ok);
      checks++; if (!ok) $display("FAIL fill_accept%0d: got 0 want 1", i);
      else passed++;
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      t_0_dat = ops[4];
      t_0_req = 1'b1;
      #1;
      checks++; if (t_0_ack !== 1'b0) $display("FAIL fill_full_ack: got %b want 0", t_0_ack);
      else passed++;
      checks++; if (inflight !== 3'd4) $display("FAIL fill_inflight: got %0d want 4", inflight);
      else passed++;
    end
    eng_stall = 0;
    acc5 = 0;
    t1_at_acc = 0;
    for (int k = 0; k < 50 && !acc5; k++) begin
      @(negedge clk);
      #1;
      if (t_0_ack) begin
        acc5 = 1;
        t1_at_acc = t1_xfers;
      end
    end
    checks++; if (!acc5) $display("FAIL fill_op5_accept: got 0 want 1");
    else passed++;
    checks++; if (t1_at_acc < 1) $display("FAIL fill_op5_early: got %0d want >=1", t1_at_acc);
    else passed++;
    idle_src();
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL fill_drain: got 0 want 1");
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) $display("FAIL fill_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL fill_order: got %h want %h", g, e);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok, seen;
    logic [15:0] held, e, g;
    sync();
    stub_fixed = 0; eng_lat = 1; sink_ack_en = 0;
    for (int i = 0; i < 3; i++) send_op({16'($urandom), 16'($urandom_range(1, 65535))}, ok);
    idle_src();
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      sync();
      if (i_1_req) seen = 1;
    end
    held = i_1_dat;
    checks++; if (!seen) $display("FAIL bp_first_req: got 0 want 1");
    else passed++;
    for (int k = 0; k < 10; k++) begin
      sync();
      checks++; if (i_1_req !== 1'b1) $display("FAIL bp_hold_req: got %b want 1", i_1_req);
      else passed++;
      checks++; if (i_1_dat !== held) $display("FAIL bp_stable: got %h want %h", i_1_dat, held);
      else passed++;
      checks++; if (t_1_ack !== 1'b0) $display("FAIL bp_t1_ack: got %b want 0", t_1_ack);
      else passed++;
    end
    sink_ack_en = 1;
    wait_drain(ok);
    // Full FIFO released at once: one quotient per cycle.
    sync();
    got_cyc.delete();
    eng_stall = 1;
    for (int i = 0; i < 4; i++) send_op({16'($urandom), 16'($urandom_range(1, 65535))}, ok);
    idle_src();
    sync(); sync(); sync();
    eng_stall = 0;
    wait_drain(ok);
    checks++; if (got_cyc.size() != 4) $display("FAIL b2b_count: got %0d want 4", got_cyc.size());
    else passed++;
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] - got_cyc[i-1] != 1)
        $display("FAIL b2b_gap: got %0d want 1", got_cyc[i] - got_cyc[i-1]);
      else passed++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) $display("FAIL bp_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL bp_order: got %h want %h", g, e);
        else passed++;
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [15:0] e, g, den;
    sync();
    stub_fixed = 0; eng_rand_ack = 1; sink_rand = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        t_0_req = 1'b0;
        #1;
      end
      eng_lat = int'($urandom_range(1, 4));
      den = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      send_op({16'($urandom), den}, ok);
    end
    idle_src();
    eng_rand_ack = 0; sink_rand = 0;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL rand_drain: got 0 want 1");
    else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rand_err: got %b want 0", err);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) $display("FAIL rand_missing: got none want %h", e);
      else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL rand_q: got %h want %h", g, e);
        else passed++;
      end
    end
    checks++; if (got_q.size() != 0) $display("FAIL rand_extra: got %0d want 0", got_q.size());
    else passed++;
  endtask

  task automatic test_stray;
    sync();
    checks++; if (inflight !== 3'd0) $display("FAIL stray_pre: got %0d want 0", inflight);
    else passed++;
    stray_pulse = 1;
    sync();
    checks++; if (t_1_ack !== 1'b1) $display("FAIL stray_ack: got %b want 1", t_1_ack);
    else passed++;
    stray_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      sync();
      checks++; if (err !== 1'b1) $display("FAIL stray_err: got %b want 1", err);
      else passed++;
      checks++; if (i_1_req !== 1'b0) $display("FAIL stray_req: got %b want 0", i_1_req);
      else passed++;
    end
    do_reset();
    #1;
    checks++; if (err !== 1'b0) $display("FAIL stray_reset_err: got %b want 0", err);
    else passed++;
  endtask

`ifdef RECIP_DIV_ZERO_BYPASS_EN
  task automatic test_bypass;
    bit ok;
    sync();
    stub_fixed = 1; stub_val = 16'h0400; eng_lat = 2; sink_ack_en = 1;
    issued_q.delete(); got_q.delete(); exp_q.delete();
    send_op(32'h000A_0005, ok);
    send_op(32'hFFFD_0000, ok);
    send_op(32'h0014_0007, ok);
    idle_src();
    wait_drain(ok);
    checks++; if (issued_q.size() != 2) $display("FAIL byp_issued: got %0d want 2", issued_q.size());
    else passed++;
    if (issued_q.size() == 2) begin
      checks++; if (issued_q[0] !== 16'd5) $display("FAIL byp_den0: got %h want 5", issued_q[0]);
      else passed++;
      checks++; if (issued_q[1] !== 16'd7) $display("FAIL byp_den1: got %h want 7", issued_q[1]);
      else passed++;
    end
    checks++; if (got_q.size() != 3) $display("FAIL byp_count: got %0d want 3", got_q.size());
    else passed++;
    if (got_q.size() == 3) begin
      checks++; if (got_q[0] !== 16'd10) $display("FAIL byp_q0: got %h want 000a", got_q[0]);
      else passed++;
      checks++; if (got_q[1] !== 16'h8000) $display("FAIL byp_q1: got %h want 8000", got_q[1]);
      else passed++;
      checks++; if (got_q[2] !== 16'd20) $display("FAIL byp_q2: got %h want 0014", got_q[2]);
      else passed++;
    end
  endtask
`else
  task automatic test_zero_den;
    bit ok;
    sync();
    stub_fixed = 1; stub_val = 16'h0400; eng_lat = 2; sink_ack_en = 1;
    issued_q.delete(); got_q.delete(); exp_q.delete();
    send_op(32'h0064_0000, ok);
    idle_src();
    wait_drain(ok);
    checks++; if (issued_q.size() != 1) $display("FAIL zden_issued: got %0d want 1", issued_q.size());
    else passed++;
    checks++; if (got_q.size() != 1) $display("FAIL zden_count: got %0d want 1", got_q.size());
    else passed++;
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== 16'd100) $display("FAIL zden_q: got %h want 0064", got_q[0]);
      else passed++;
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    t_0_req = 1'b0;
    t_0_dat = '0;
    test_reset();
    test_single();
    test_saturation();
    test_fill();
    test_back_to_back();
    test_random();
    test_stray();
`ifdef RECIP_DIV_ZERO_BYPASS_EN
    test_bypass();
`else
    test_zero_den();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
